// File: rtl/ipv4_csum_ttl_update.sv
// ipv4_csum_ttl_update: verifies the IPv4 header checksum, drops bad packets, redirects TTL<=1 to the CPU port; `IPV4_TTL_DECREMENT_EN adds TTL-1 with checksum patch.
// Latency: beat 0 one cycle after beat-1 accept, beat 1 the cycle after, later beats one cycle after accept.
// Backpressure: S_AXIS_TREADY needs >=2 free entries in the depth-8 output FIFO (always high while dropping).

// sync_fifo: generic single-clock fallthrough FIFO, head visible while rd_vld is high.
// Latency: a write is visible on rd_dat the cycle after it is accepted.
// Backpressure: writes to a full FIFO are ignored unless a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   free_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld   = (count != '0);
  assign rd_dat   = mem[rd_ptr];
  assign do_rd    = rd_vld && rd_rdy;
  assign do_wr    = wr_vld && ((count != FULL) || do_rd);
  assign free_cnt = FULL - count;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ipv4_csum_ttl_update #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic [31:0]                       CSUM_PART_A,
  input  logic [31:0]                       CSUM_PART_B,
  input  logic [15:0]                       LOW_IP_ADDR,
  output logic [31:0]                       BAD_CSUM_COUNT,
  output logic [31:0]                       TTL_EXP_COUNT
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [SW-1:0] tstrb;
    logic [UW-1:0] tuser;
    logic          tlast;
  } beat_t;

  typedef enum logic [2:0] {IDLE, HOLD, FLUSH, PASS, DROP} state_t;

  state_t        state;
  logic [DW-1:0] hdr_dat;
  logic [SW-1:0] hdr_strb;
  logic [UW-1:0] hdr_user;
  logic [DW-1:0] b1_dat;
  logic [SW-1:0] b1_strb;
  logic          b1_last;
  logic [UW-1:0] pkt_user;

  logic          s_acc;
  logic          room;
  logic [3:0]    free_cnt;
  logic          fifo_wr_vld;
  beat_t         fifo_wr_dat;
  logic          fifo_rd_vld;
  beat_t         fifo_rd_dat;
  beat_t         b0_out;

  logic          is_ipv4;
  logic [33:0]   csum_sum;
  logic [18:0]   fold1;
  logic [16:0]   fold2;
  logic          csum_ok;
  logic [7:0]    ttl;
  logic          drop;
  logic          expire;

  assign room  = (free_cnt >= 4'd2);
  assign s_acc = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (state)
      IDLE, HOLD, PASS: S_AXIS_TREADY = room;
      DROP:             S_AXIS_TREADY = 1'b1;
      default:          S_AXIS_TREADY = 1'b0;
    endcase
    if (AXI_RESET) S_AXIS_TREADY = 1'b0;
  end

  // Checksum inputs are only meaningful in the cycle beat 1 is accepted.
  assign is_ipv4  = (hdr_dat[159:144] == 16'h0800) && (hdr_dat[143:136] == 8'h45);
  assign csum_sum = {2'b0, CSUM_PART_A} + {2'b0, CSUM_PART_B} + {18'b0, LOW_IP_ADDR};
  assign fold1    = {3'b0, csum_sum[15:0]} + {1'b0, csum_sum[33:16]};
  assign fold2    = {1'b0, fold1[15:0]} + {14'b0, fold1[18:16]};
  assign csum_ok  = (fold2 == 17'h0FFFF);
  assign ttl      = hdr_dat[79:72];
  assign drop     = is_ipv4 && !csum_ok;
  assign expire   = is_ipv4 && csum_ok && (ttl <= 8'd1);

`ifdef IPV4_TTL_DECREMENT_EN
  logic [16:0] hc_sum;
  assign hc_sum = {1'b0, hdr_dat[63:48]} + 17'h00100;
`endif

  always_comb begin
    b0_out.tdata = hdr_dat;
    b0_out.tstrb = hdr_strb;
    b0_out.tuser = hdr_user;
    b0_out.tlast = 1'b0;
    if (expire) begin
      b0_out.tuser[DST_PORT_POS +: 8] = {hdr_user[SRC_PORT_POS +: 7], 1'b0};
    end
`ifdef IPV4_TTL_DECREMENT_EN
    else if (is_ipv4) begin
      b0_out.tdata[79:72] = ttl - 8'd1;
      b0_out.tdata[63:48] = hc_sum[15:0] + {15'b0, hc_sum[16]};
    end
`endif
  end

  always_comb begin
    fifo_wr_vld = 1'b0;
    fifo_wr_dat = {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
    case (state)
      IDLE: fifo_wr_vld = s_acc && S_AXIS_TLAST;
      HOLD: begin
        fifo_wr_vld = s_acc && !drop;
        fifo_wr_dat = b0_out;
      end
      FLUSH: begin
        fifo_wr_vld = 1'b1;
        fifo_wr_dat = {b1_dat, b1_strb, pkt_user, b1_last};
      end
      PASS: begin
        fifo_wr_vld       = s_acc;
        fifo_wr_dat.tuser = pkt_user;
      end
      default: fifo_wr_vld = 1'b0;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (state == IDLE && s_acc && !S_AXIS_TLAST) begin
      hdr_dat  <= S_AXIS_TDATA;
      hdr_strb <= S_AXIS_TSTRB;
      hdr_user <= S_AXIS_TUSER;
    end
    if (state == HOLD && s_acc) begin
      b1_dat   <= S_AXIS_TDATA;
      b1_strb  <= S_AXIS_TSTRB;
      b1_last  <= S_AXIS_TLAST;
      pkt_user <= b0_out.tuser;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      state          <= IDLE;
      BAD_CSUM_COUNT <= '0;
      TTL_EXP_COUNT  <= '0;
    end else begin
      case (state)
        IDLE: if (s_acc && !S_AXIS_TLAST) state <= HOLD;
        HOLD: if (s_acc) begin
          if (drop) begin
            BAD_CSUM_COUNT <= BAD_CSUM_COUNT + 32'd1;
            state          <= S_AXIS_TLAST ? IDLE : DROP;
          end else begin
            if (expire) TTL_EXP_COUNT <= TTL_EXP_COUNT + 32'd1;
            state <= FLUSH;
          end
        end
        FLUSH:   state <= b1_last ? IDLE : PASS;
        PASS:    if (s_acc && S_AXIS_TLAST) state <= IDLE;
        DROP:    if (s_acc && S_AXIS_TLAST) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH ($bits(beat_t)),
    .DEPTH (8)
  ) u_out_fifo (
    .clk      (AXI_ACLK),
    .rst      (AXI_RESET),
    .wr_vld   (fifo_wr_vld),
    .wr_dat   (fifo_wr_dat),
    .rd_vld   (fifo_rd_vld),
    .rd_rdy   (M_AXIS_TREADY),
    .rd_dat   (fifo_rd_dat),
    .free_cnt (free_cnt)
  );

  assign M_AXIS_TVALID = fifo_rd_vld;
  assign M_AXIS_TDATA  = fifo_rd_dat.tdata;
  assign M_AXIS_TSTRB  = fifo_rd_dat.tstrb;
  assign M_AXIS_TUSER  = fifo_rd_dat.tuser;
  assign M_AXIS_TLAST  = fifo_rd_vld && fifo_rd_dat.tlast;
endmodule

// File: tb/tb_ipv4_csum_ttl_update.sv
// Bench for ipv4_csum_ttl_update: random and directed packets, scoreboard against a packet-level reference model.
module tb_ipv4_csum_ttl_update;
  localparam int SRC = 16;
  localparam int DST = 24;

  logic          AXI_ACLK = 1'b0;
  logic          AXI_RESET = 1'b1;
  logic [255:0]  S_AXIS_TDATA = '0;
  logic [31:0]   S_AXIS_TSTRB = '0;
  logic [127:0]  S_AXIS_TUSER = '0;
  logic          S_AXIS_TVALID = 1'b0;
  logic          S_AXIS_TLAST = 1'b0;
  logic          S_AXIS_TREADY;
  logic [255:0]  M_AXIS_TDATA;
  logic [31:0]   M_AXIS_TSTRB;
  logic [127:0]  M_AXIS_TUSER;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TREADY = 1'b1;
  logic [31:0]   CSUM_PART_A = '0;
  logic [31:0]   CSUM_PART_B = '0;
  logic [15:0]   LOW_IP_ADDR = '0;
  logic [31:0]   BAD_CSUM_COUNT;
  logic [31:0]   TTL_EXP_COUNT;

  always #5 AXI_ACLK = ~AXI_ACLK;

  ipv4_csum_ttl_update dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESET      (AXI_RESET),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TSTRB   (S_AXIS_TSTRB),
    .S_AXIS_TUSER   (S_AXIS_TUSER),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TSTRB   (M_AXIS_TSTRB),
    .M_AXIS_TUSER   (M_AXIS_TUSER),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .CSUM_PART_A    (CSUM_PART_A),
    .CSUM_PART_B    (CSUM_PART_B),
    .LOW_IP_ADDR    (LOW_IP_ADDR),
    .BAD_CSUM_COUNT (BAD_CSUM_COUNT),
    .TTL_EXP_COUNT  (TTL_EXP_COUNT)
  );

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       pkt[$];
  beat_t       exp_q[$];
  logic [31:0] pa, pb;
  logic [15:0] plow;
  int          checks = 0;
  int          errors = 0;
  int          exp_bad = 0;
  int          exp_ttl = 0;
  bit          rand_bp = 1'b0;
  bit          m_rdy = 1'b1;
  beat_t       mon_act, mon_exp;

  function automatic void check(string nm, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: what the packet in pkt[] should look like at the output, if anything.
  function automatic void model();
    beat_t           b0;
    logic [127:0]    u;
    longint unsigned s, f;
    int unsigned     ttl, hc;
    bit              ipv4;
    b0 = pkt[0];
    if (b0.l) begin
      exp_q.push_back(b0);
      return;
    end
    ipv4 = (b0.d[159:144] == 16'h0800) && (b0.d[143:136] == 8'h45);
    s = 64'(pa) + 64'(pb) + 64'(plow);
    f = (s % 65536) + (s / 65536);
    f = (f % 65536) + (f / 65536);
    if (ipv4 && f != 64'd65535) begin
      exp_bad++;
      return;
    end
    u   = b0.u;
    ttl = 32'(b0.d[79:72]);
    hc  = 32'(b0.d[63:48]);
    if (ipv4 && ttl <= 1) begin
      u[DST +: 8] = 8'(32'(b0.u[SRC +: 8]) * 2);
      exp_ttl++;
    end
`ifdef IPV4_TTL_DECREMENT_EN
    else if (ipv4) begin
      hc = hc + 256;
      if (hc > 65535) hc = hc - 65535;
      b0.d[79:72] = 8'(ttl - 1);
      b0.d[63:48] = 16'(hc);
    end
`endif
    b0.u = u;
    exp_q.push_back(b0);
    for (int i = 1; i < pkt.size(); i++) begin
      beat_t b = pkt[i];
      b.u = u;
      exp_q.push_back(b);
    end
  endfunction

  task automatic build(input int n, input logic [15:0] et, input logic [7:0] vi, input logic [7:0] ttl,
                       input logic [15:0] hc, input logic [7:0] src, input bit good);
    beat_t           b;
    longint unsigned s;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      b.d = {8{$urandom}};
      b.s = $urandom;
      b.u = {$urandom, $urandom, $urandom, $urandom};
      b.l = (i == n - 1);
      if (i == 0) begin
        b.d[159:144] = et;
        b.d[143:136] = vi;
        b.d[79:72]   = ttl;
        b.d[63:48]   = hc;
        b.u[SRC +: 8] = src;
      end
      pkt.push_back(b);
    end
    // Any multiple of 0xFFFF folds to 0xFFFF; nudging LOW by one breaks it.
    plow = 16'($urandom_range(0, 32'hFFFE));
    s    = 64'($urandom_range(2, 65000)) * 64'hFFFF;
    pa   = 32'($urandom_range(0, 32'(s - 64'(plow))));
    pb   = 32'(s - 64'(pa) - 64'(plow));
    if (!good) plow = plow + 16'd1;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge AXI_ACLK);
    while (!S_AXIS_TREADY && n < 2000) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (!S_AXIS_TREADY) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: S_AXIS_TREADY stuck at 0, required 1");
    end
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic send(input int upto);
    for (int i = 0; i < upto; i++) begin
      S_AXIS_TDATA  = pkt[i].d;
      S_AXIS_TSTRB  = pkt[i].s;
      S_AXIS_TUSER  = pkt[i].u;
      S_AXIS_TLAST  = pkt[i].l;
      S_AXIS_TVALID = 1'b1;
      if (i == 1) begin
        CSUM_PART_A = pa;
        CSUM_PART_B = pb;
        LOW_IP_ADDR = plow;
      end else begin
        CSUM_PART_A = $urandom;
        CSUM_PART_B = $urandom;
        LOW_IP_ADDR = 16'($urandom);
      end
      wait_accept();
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic send_pkt();
    model();
    send(pkt.size());
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge AXI_ACLK);
      n++;
    end
    repeat (3) @(posedge AXI_ACLK);
    #1;
    check({nm, "_pending_beats"}, exp_q.size(), 0);
    check({nm, "_bad_csum_count"}, BAD_CSUM_COUNT, exp_bad);
    check({nm, "_ttl_exp_count"}, TTL_EXP_COUNT, exp_ttl);
  endtask

  always @(posedge AXI_ACLK) begin
    #1;
    M_AXIS_TREADY = rand_bp ? ($urandom_range(0, 3) != 0) : m_rdy;
  end

  always @(negedge AXI_ACLK) begin
    if (!AXI_RESET && M_AXIS_TVALID && M_AXIS_TREADY) begin
      mon_act = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h expected no beat", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL out_beat: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  int nb;
  logic [15:0] et;
  logic [7:0]  vi, tt;

  initial begin
    repeat (3) @(posedge AXI_ACLK);
    #1;
    check("rst_m_tvalid", M_AXIS_TVALID, 0);
    check("rst_m_tlast", M_AXIS_TLAST, 0);
    check("rst_s_tready", S_AXIS_TREADY, 0);
    check("rst_bad_cnt", BAD_CSUM_COUNT, 0);
    check("rst_ttl_cnt", TTL_EXP_COUNT, 0);
    AXI_RESET = 1'b0;
    #1;
    check("tready_after_rst", S_AXIS_TREADY, 1);
    @(posedge AXI_ACLK);
    #1;

    build(3, 16'h0800, 8'h45, 8'h40, 16'hB1E6, 8'h01, 1'b1);
    send_pkt();
    drain("good_ipv4");

    build(3, 16'h0800, 8'h45, 8'h40, 16'hB1E6, 8'h01, 1'b0);
    send_pkt();
    build(3, 16'h0800, 8'h45, 8'h40, 16'hB1E6, 8'h02, 1'b1);
    send_pkt();
    drain("bad_csum");

    build(3, 16'h0800, 8'h45, 8'h01, 16'h1234, 8'h04, 1'b1);
    send_pkt();
    drain("ttl_expire");

    build(2, 16'h0800, 8'h45, 8'h20, 16'hFEFF, 8'h01, 1'b1);
    send_pkt();
    build(2, 16'h0800, 8'h45, 8'h20, 16'hFF00, 8'h01, 1'b1);
    send_pkt();
    drain("hc_carry");

    build(3, 16'h0806, 8'h45, 8'h01, 16'h0000, 8'h10, 1'b0);
    send_pkt();
    build(2, 16'h0800, 8'h46, 8'h01, 16'h0000, 8'h10, 1'b0);
    send_pkt();
    build(1, 16'h0800, 8'h45, 8'h01, 16'h0000, 8'h10, 1'b0);
    send_pkt();
    build(2, 16'h0800, 8'h45, 8'h00, 16'hABCD, 8'h20, 1'b0);
    send_pkt();
    drain("non_ipv4_1beat");

    rand_bp = 1'b1;
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 5);
      et = ($urandom_range(0, 4) != 0) ? 16'h0800 : 16'h0806;
      vi = ($urandom_range(0, 4) != 0) ? 8'h45 : 8'h46;
      tt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      build(nb, et, vi, tt, 16'($urandom), 8'(1 << $urandom_range(0, 7)), $urandom_range(0, 4) != 0);
      send_pkt();
    end
    drain("random");

    rand_bp = 1'b0;
    m_rdy   = 1'b0;
    @(posedge AXI_ACLK);
    #1;
    fork
      begin
        for (int p = 0; p < 3; p++) begin
          build(4, 16'h0800, 8'h45, 8'h40, 16'($urandom), 8'h01, 1'b1);
          send_pkt();
        end
      end
      begin
        repeat (20) @(posedge AXI_ACLK);
        #2;
        check("bp_s_tready_stalled", S_AXIS_TREADY, 0);
        check("bp_m_tvalid_held", M_AXIS_TVALID, 1);
        m_rdy = 1'b1;
      end
    join
    drain("backpressure");

    m_rdy = 1'b0;
    build(6, 16'h0800, 8'h45, 8'h40, 16'h5555, 8'h01, 1'b1);
    send(4);
    AXI_RESET = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    check("midrst_m_tvalid", M_AXIS_TVALID, 0);
    check("midrst_s_tready", S_AXIS_TREADY, 0);
    check("midrst_bad_cnt", BAD_CSUM_COUNT, 0);
    AXI_RESET = 1'b0;
    exp_q.delete();
    exp_bad = 0;
    exp_ttl = 0;
    m_rdy   = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    build(3, 16'h0800, 8'h45, 8'h01, 16'h4321, 8'h08, 1'b1);
    send_pkt();
    build(2, 16'h0800, 8'h45, 8'h33, 16'h7777, 8'h01, 1'b1);
    send_pkt();
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
